// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Round-robin grant in IDLE. Operands are registered into the ALU for one
// EXEC cycle. The result is then held in RESP until the granted requester
// accepts it.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no operation in flight, arbitrating requesters
// EXEC  | latched operands driving the ALU for one cycle
// RESP  | captured result held for the granted requester
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 2
) (
    input  logic             clk,
    input  logic             rstn,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_c,
    output logic             resp0_zero,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_c,
    output logic             resp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic             grant_id;
    logic             last_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [OPW-1:0]   op_op;
    logic [WIDTH-1:0] res_c;
    logic             res_zero;

    // Arbitration results, not yet gated by reset; these feed the flops.
    logic             start0;
    logic             start1;
    logic             resp_take;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, round-robin arbitration and handshake outputs.
    always_comb begin
        state_d     = state_q;
        start0      = 1'b0;
        start1      = 1'b0;
        resp_take   = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not finish last wins.
                start0 = req0_valid && (!req1_valid || last_id);
                start1 = req1_valid && (!req0_valid || !last_id);
                if (start0 || start1) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                resp0_valid = !grant_id;
                resp1_valid = grant_id;
                resp_take   = grant_id ? resp1_ready : resp0_ready;
                if (resp_take) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is combinational from the valids; forced low while reset is held
    // so nothing is accepted before the block is out of reset.
    assign req0_ready = start0 && rstn;
    assign req1_ready = start1 && rstn;

    // Operand latch, result capture and round-robin history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_id <= 1'b0;
            last_id  <= 1'b1;
            op_a     <= '0;
            op_b     <= '0;
            op_op    <= '0;
            res_c    <= '0;
            res_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start0) begin
                        op_a     <= req0_a;
                        op_b     <= req0_b;
                        op_op    <= req0_op;
                        grant_id <= 1'b0;
                    end else if (start1) begin
                        op_a     <= req1_a;
                        op_b     <= req1_b;
                        op_op    <= req1_op;
                        grant_id <= 1'b1;
                    end
                end
                EXEC: begin
                    res_c    <= alu_c;
                    res_zero <= alu_zero;
                end
                RESP: begin
                    if (resp_take) begin
                        last_id <= grant_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The ALU only ever sees the registered operands.
    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_op     = op_op;

    // Both response ports show the held result; only the valid one matters.
    assign resp0_c    = res_c;
    assign resp0_zero = res_zero;
    assign resp1_c    = res_c;
    assign resp1_zero = res_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors against alu_arbiter with a stub ALU.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 2;

    localparam logic [OPW-1:0] ALUOp_ADDU = 2'd0;
    localparam logic [OPW-1:0] ALUOp_SUBU = 2'd1;
    localparam logic [OPW-1:0] ALUOp_AND  = 2'd2;
    localparam logic [OPW-1:0] ALUOp_OR   = 2'd3;

    logic             clk;
    logic             rstn;
    logic             req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
    logic             req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, resp0_c, resp1_c;
    logic [OPW-1:0]   req0_op, req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_c;
    logic [OPW-1:0]   alu_op;
    logic             alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_c(resp0_c), .resp0_zero(resp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_c(resp1_c), .resp1_zero(resp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_zero(alu_zero)
    );

    // Stub of the external ALU.
    always_comb begin
        case (alu_op)
            ALUOp_ADDU: alu_c = alu_a + alu_b;
            ALUOp_SUBU: alu_c = alu_a - alu_b;
            ALUOp_AND:  alu_c = alu_a & alu_b;
            default:    alu_c = alu_a | alu_b;
        endcase
        alu_zero = (alu_a == alu_b);
    end

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid  = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid  = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_req0_ready",  {31'd0, req0_ready},  32'd0);
        chk("rst_req1_ready",  {31'd0, req1_ready},  32'd0);
        chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        chk("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
        chk("rst_alu_a",       alu_a,                32'd0);
        chk("rst_resp0_c",     resp0_c,              32'd0);
        rstn = 1'b1;
        tick();
    endtask

    // One complete operation on requester n with no contention.
    task automatic do_op(input bit n, input logic [31:0] a, input logic [31:0] b,
                         input logic [OPW-1:0] op, input logic [31:0] ec, input bit ez);
        if (n) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        chk("op_ready_idle", {31'd0, (n ? req1_ready : req0_ready)}, 32'd1);
        chk("op_other_ready_idle", {31'd0, (n ? req0_ready : req1_ready)}, 32'd0);
        tick();
        // EXEC: valid still high, ready must stay low.
        chk("op_ready_exec", {31'd0, (n ? req1_ready : req0_ready)}, 32'd0);
        chk("op_alu_a", alu_a, a);
        chk("op_alu_b", alu_b, b);
        chk("op_alu_op", {30'd0, alu_op}, {30'd0, op});
        chk("op_resp_early", {31'd0, (n ? resp1_valid : resp0_valid)}, 32'd0);
        tick();
        chk("op_ready_resp", {31'd0, (n ? req1_ready : req0_ready)}, 32'd0);
        chk("op_resp_valid", {31'd0, (n ? resp1_valid : resp0_valid)}, 32'd1);
        chk("op_other_valid", {31'd0, (n ? resp0_valid : resp1_valid)}, 32'd0);
        chk("op_resp_c", (n ? resp1_c : resp0_c), ec);
        chk("op_resp_zero", {31'd0, (n ? resp1_zero : resp0_zero)}, {31'd0, ez});
        if (n) begin
            req1_valid = 1'b0; resp1_ready = 1'b1;
        end else begin
            req0_valid = 1'b0; resp0_ready = 1'b1;
        end
        tick();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        chk("op_resp_done", {31'd0, (n ? resp1_valid : resp0_valid)}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();

        // Single ADDU, then SUBU wrap and equal operands.
        do_reset();
        do_op(1'b0, 32'd5, 32'd7, ALUOp_ADDU, 32'd12, 1'b0);
        do_op(1'b1, 32'd0, 32'd1, ALUOp_SUBU, 32'hFFFF_FFFF, 1'b0);
        do_op(1'b1, 32'h1234, 32'h1234, ALUOp_SUBU, 32'd0, 1'b1);
        do_op(1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, ALUOp_AND, 32'h00F0_000F, 1'b0);

        // Tie with both continuously valid: grants 0,1,0,1 every 3 cycles.
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2; req0_op = ALUOp_ADDU;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_op = ALUOp_SUBU;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bit g;
            g = ((k / 3) % 2) == 1;
            #1;
            chk("rr_ready0", {31'd0, req0_ready}, {31'd0, (k % 3 == 0) && !g});
            chk("rr_ready1", {31'd0, req1_ready}, {31'd0, (k % 3 == 0) && g});
            chk("rr_valid0", {31'd0, resp0_valid}, {31'd0, (k % 3 == 2) && !g});
            chk("rr_valid1", {31'd0, resp1_valid}, {31'd0, (k % 3 == 2) && g});
            if (k % 3 == 2) begin
                chk("rr_c", (g ? resp1_c : resp0_c), (g ? 32'd7 : 32'd3));
            end
            tick();
        end
        idle_inputs();

        // Result backpressure on requester 0 while requester 1 waits.
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23; req0_op = ALUOp_ADDU;
        req1_valid = 1'b1; req1_a = 32'd8;   req1_b = 32'd8;  req1_op = ALUOp_SUBU;
        #1;
        chk("bp_ready0", {31'd0, req0_ready}, 32'd1);
        chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("bp_exec_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", {31'd0, resp0_valid}, 32'd1);
            chk("bp_hold_c", resp0_c, 32'd123);
            chk("bp_hold_ready1", {31'd0, req1_ready}, 32'd0);
            tick();
        end
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        chk("bp_resp0_cleared", {31'd0, resp0_valid}, 32'd0);
        chk("bp_ready1_after", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_resp1_valid", {31'd0, resp1_valid}, 32'd1);
        chk("bp_resp1_c", resp1_c, 32'd0);
        chk("bp_resp1_zero", {31'd0, resp1_zero}, 32'd1);
        resp1_ready = 1'b1;
        tick();
        resp1_ready = 1'b0;

        // Reset asserted during EXEC with both requesters still valid.
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_op = ALUOp_ADDU;
        tick();
        req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd2; req1_op = ALUOp_SUBU;
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("mid_rst_valid0", {31'd0, resp0_valid}, 32'd0);
        chk("mid_rst_valid1", {31'd0, resp1_valid}, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        #1;
        chk("post_rst_valid0", {31'd0, resp0_valid}, 32'd0);
        chk("post_rst_valid1", {31'd0, resp1_valid}, 32'd0);
        chk("post_rst_tie0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_tie1", {31'd0, req1_ready}, 32'd0);
        idle_inputs();
        tick();

        // Requester 1 streaming alone despite last_id pointing at it.
        do_reset();
        do_op(1'b1, 32'd3, 32'd4, ALUOp_ADDU, 32'd7, 1'b0);
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, ALUOp_ADDU, 32'd0, 1'b1);
        do_op(1'b1, 32'h0000_00F0, 32'h0000_000F, ALUOp_OR, 32'h0000_00FF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
